// File: rtl/tx_ffe_mac.sv
// tx_ffe_mac: runtime-weighted TX FIR equaliser with double-buffered taps, NRZ/PAM4 symbols and saturating output
module tx_ffe_mac #(
  parameter int N_TAPS = 4,
  parameter int MAIN_TAP = 1,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH = 12,
  localparam int ADDR_WIDTH = $clog2(N_TAPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     in,
  input  logic                           pam4,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] wr_data,
  input  logic                           commit,
  output logic                           commit_ack,
  output logic signed [OUT_WIDTH-1:0]    out,
  output logic                           out_valid,
  output logic                           sat
);
  localparam int PW = WEIGHT_WIDTH + 2;
  localparam int SW = PW + $clog2(N_TAPS);
  localparam int XW = SW > OUT_WIDTH ? SW : OUT_WIDTH;
  localparam int CW = $clog2(N_TAPS + 2) + 1;
  localparam logic signed [WEIGHT_WIDTH-1:0] W_MAIN = WEIGHT_WIDTH'(1 << (WEIGHT_WIDTH - 2));
  localparam logic signed [XW-1:0] OMAX = XW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] OMIN = ~OMAX;

  // raw code to signed level: PAM4 is 2c-3 (top bit flipped), NRZ uses bit 0 only
  function automatic logic signed [2:0] level(input logic [1:0] c, input logic m);
    return m ? {~c[1], c[0], 1'b1} : {~c[0], ~c[0], 1'b1};
  endfunction

  logic [1:0]                     hist   [N_TAPS];
  logic signed [WEIGHT_WIDTH-1:0] shadow [N_TAPS];
  logic signed [WEIGHT_WIDTH-1:0] active [N_TAPS];
  logic signed [PW-1:0]           prod   [N_TAPS];
  logic                           mode;
  logic signed [SW-1:0]           sum;
  logic signed [XW-1:0]           sum_x;
  logic [CW-1:0]                  cnt;
  logic                           valid_nxt;
  logic                           clip_hi;
  logic                           clip_lo;

  // symbol history of raw codes, newest at index 0; mapping happens later so a mode change covers all entries
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) hist[k] <= '0;
    end else begin
      hist[0] <= in;
      for (int k = 1; k < N_TAPS; k++) hist[k] <= hist[k-1];
    end

  // shadow bank takes writes; commit loads active bank and mode from the pre-edge shadow in one step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shadow[k] <= k == MAIN_TAP ? W_MAIN : '0;
        active[k] <= k == MAIN_TAP ? W_MAIN : '0;
      end
      mode <= 1'b0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (commit) active[k] <= shadow[k];
        if (wr_en && wr_addr == ADDR_WIDTH'(k)) shadow[k] <= wr_data;
      end
      if (commit) mode <= pam4;
    end

  // product stage: every tap uses the same active weight set and mode on a given edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) prod[k] <= '0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) prod[k] <= PW'(active[k]) * PW'(level(hist[k], mode));
    end

  // full-precision sum, clip detection and warm-up qualification for the output register
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_TAPS; k++) sum = sum + SW'(prod[k]);
    sum_x = XW'(sum);
    clip_hi = sum_x > OMAX;
    clip_lo = sum_x < OMIN;
    valid_nxt = out_valid || cnt == CW'(N_TAPS + 1);
  end

  // output register masked to zero until history and pipeline hold only real symbols
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      out_valid <= 1'b0;
      out <= '0;
      sat <= 1'b0;
      commit_ack <= 1'b0;
    end else begin
      cnt <= out_valid ? cnt : cnt + CW'(1);
      out_valid <= valid_nxt;
      out <= !valid_nxt ? '0 : clip_hi ? OUT_WIDTH'(OMAX) : clip_lo ? OUT_WIDTH'(OMIN) : OUT_WIDTH'(sum_x);
      sat <= valid_nxt && (clip_hi || clip_lo);
      commit_ack <= commit;
    end
endmodule
